regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Sequential read-out engine for the MIPS register file. On a start pulse it walks a contiguous range of register indices through one register-file read port and streams each 32-bit value out over a valid/ready handshake. It is the reading counterpart of the register-file write path and is used for debug dumps and end-of-program result checking. It sits beside the datapath, sharing the register file's `ReadRegister1`/`ReadData1` port through a debug mux outside this block.

## Interface
Parameters:
- `NUM_REGS`, 32: register count. Indices are 5 bits; walks wrap modulo `NUM_REGS`.

Ports (one clock; reset is asynchronous and active-low):
- `Clk` in 1: the single clock; all state changes on its rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: single-cycle request; sampled only in IDLE.
- `FirstReg` in 5: first index, sampled with `Start`.
- `LastReg` in 5: last index, sampled with `Start`.
- `ReadRegister` out 5: index driven to the register-file read port.
- `ReadData` in 32: combinational read data returned by the register file.
- `DumpValid` out 1: output beat valid.
- `DumpReady` in 1: consumer accepts the beat.
- `DumpIndex` out 5: register index of the current beat.
- `DumpData` out 32: register value of the current beat.
- `DumpLast` out 1: current beat is the final beat.
- `DumpSum` out 1: current beat carries the checksum. Constant 0 without the macro.
- `Busy` out 1: high from the cycle after `Start` is accepted until `Done`.
- `Done` out 1: one-cycle pulse at completion.

## Operation
- States:
  - IDLE: `Start` → READ.
  - READ: captures `ReadData` into `DumpData`, then → HOLD.
  - HOLD: on a transfer, if more registers remain → READ; else if the checksum is enabled → SUM; else → FIN.
  - SUM: on a transfer → FIN.
  - FIN: → IDLE.
- Beat count = ((`LastReg` − `FirstReg`) mod 32) + 1.
  - `FirstReg` > `LastReg` wraps 31→0. Example: 30..1 gives 30, 31, 0, 1.
  - `FirstReg` == `LastReg` gives one beat.
- `ReadRegister` holds the current index during READ. It is 0 in every other state except HOLD, where it keeps the last index.
- Transfer occurs on a rising edge with `DumpValid` && `DumpReady`.
  - While `DumpValid` && !`DumpReady`, `DumpData`, `DumpIndex`, `DumpLast` and `DumpSum` are held stable.
  - `DumpValid` never drops without a transfer, except on reset.
- `Start` while `Busy` is ignored. `Start` in FIN is ignored.
- `DumpData` is whatever `ReadData` shows at the capturing edge. A register-file write in the same cycle gives the register file's own read-during-write result; this block adds no bypass.
- Reset (any state, including mid-dump):
  - State returns to IDLE and the range is discarded.
  - All outputs go to 0 immediately (asynchronous): `ReadRegister`, `DumpValid`, `DumpIndex`, `DumpData`, `DumpLast`, `DumpSum`, `Busy`, `Done`.

## Timing
- Edge N: `Start` sampled.
- N+1: READ, `ReadRegister` = `FirstReg`, `Busy` = 1.
- N+2: HOLD, `DumpValid` = 1.
- Each further beat follows 2 cycles after the previous transfer (1 READ + 1 HOLD). Peak throughput is 1 beat per 2 cycles.
- `Done` pulses in the cycle after the final transfer (FIN). `Busy` is 0 in that same cycle.
- Minimum single-register dump, `DumpReady` tied high: `Start` to `Done` = 3 cycles without checksum, 4 with.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN` defined:
  - A 32-bit accumulator adds every data beat at its transfer, wrapping modulo 2^32. It is cleared on `Start` accept and on reset.
  - After the last register beat, one extra beat follows with `DumpSum` = 1, `DumpIndex` = 0, `DumpData` = sum, `DumpLast` = 1.
  - On that last register beat, `DumpLast` = 0.
- Undefined:
  - No SUM state and no accumulator.
  - `DumpLast` = 1 on the last register beat.
  - `DumpSum` is tied 0.

## Structure
- Shared package `regfile_dump_pkg`: state encoding (IDLE, READ, HOLD, SUM, FIN), `NUM_REGS`, index width 5, data width 32.
- Sub-module `dump_checksum_acc` (clear, add-enable, 32-bit sum). It is instantiated only under `REGFILE_DUMP_CHECKSUM_EN`.

## Test plan
- Preload regs 8..11 = 1, 2, 3, 4; `Start`, First = 8, Last = 11, `DumpReady` = 1:
  - Beats (8,1), (9,2), (10,3), (11,4), each 2 cycles apart.
  - `DumpLast` on index 11 (no macro).
  - `Done` 1 cycle after the last transfer.
- Same dump with the macro: extra beat `DumpSum` = 1, data = 10, `DumpLast` = 1; index 11 has `DumpLast` = 0.
- `DumpReady` low for 5 cycles on beat index 9 → `DumpData` = 2 and `DumpIndex` = 9 held stable throughout; no beat lost or duplicated.
- Wrap: First = 30, Last = 1, reg 30 = 0xDEADBEEF, reg 31 = 7 → 4 beats in order 30, 31, 0, 1, with data 0xDEADBEEF, 7, 0, reg 1 value.
- `Start` pulsed while `Busy` with First = 2, Last = 2 → ignored; the original range completes unchanged.
- `Reset_n` low mid-dump (during HOLD of the 2nd beat) → all outputs 0 immediately; after release, a fresh `Start`, First = 5, Last = 5, gives a single beat for reg 5.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader: state encoding,
// register count, index/data widths and the wrapping index increment.
package regfile_dump_pkg;

   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;
   localparam int DATA_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_HOLD,
      ST_SUM,
      ST_FIN
   } state_e;

   // Walks wrap from the top register back to index 0.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int unsigned        n);
      return (idx == IDX_W'(n - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/dump_checksum_acc.sv
// 32-bit wrapping accumulator for the dump checksum beat; cleared when a new
// dump is accepted, adds one data beat per enabled cycle.
module dump_checksum_acc (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               clear_i,
   input  logic                               add_en_i,
   input  logic [regfile_dump_pkg::DATA_W-1:0] data_i,
   output logic [regfile_dump_pkg::DATA_W-1:0] sum_o
);
   import regfile_dump_pkg::*;

   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (add_en_i) begin
         sum_d = sum_q + data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous (wrapping) range of register-file entries out over a
// valid/ready port. Define REGFILE_DUMP_CHECKSUM_EN to append a checksum beat.
module regfile_dump_reader #(
   parameter int NUM_REGS = regfile_dump_pkg::NUM_REGS
) (
   input  logic                                Clk,
   input  logic                                Reset_n,
   input  logic                                Start,
   input  logic [regfile_dump_pkg::IDX_W-1:0]  FirstReg,
   input  logic [regfile_dump_pkg::IDX_W-1:0]  LastReg,
   output logic [regfile_dump_pkg::IDX_W-1:0]  ReadRegister,
   input  logic [regfile_dump_pkg::DATA_W-1:0] ReadData,
   output logic                                DumpValid,
   input  logic                                DumpReady,
   output logic [regfile_dump_pkg::IDX_W-1:0]  DumpIndex,
   output logic [regfile_dump_pkg::DATA_W-1:0] DumpData,
   output logic                                DumpLast,
   output logic                                DumpSum,
   output logic                                Busy,
   output logic                                Done
);
   import regfile_dump_pkg::*;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cur_q, cur_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              in_hold, in_sum;

   assign in_hold = (state_q == ST_HOLD);
   assign in_sum  = (state_q == ST_SUM);

`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum;

   dump_checksum_acc u_acc (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .clear_i  ((state_q == ST_IDLE) && Start),
      .add_en_i (in_hold && DumpReady),
      .data_i   (data_q),
      .sum_o    (sum)
   );
`endif

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               cur_d   = FirstReg;
               last_d  = LastReg;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            data_d  = ReadData;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (DumpReady) begin
               if (cur_q != last_q) begin
                  cur_d   = next_idx(cur_q, NUM_REGS);
                  state_d = ST_READ;
               end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  state_d = ST_SUM;
`else
                  state_d = ST_FIN;
`endif
               end
            end
         end
         ST_SUM: begin
            if (DumpReady) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            // Start is deliberately not sampled here.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode from registered state only, so reset clears them at once.
   always_comb begin
      ReadRegister = (state_q == ST_READ || in_hold) ? cur_q : '0;
      DumpValid    = in_hold || in_sum;
      DumpIndex    = in_hold ? cur_q : '0;
      Busy         = (state_q == ST_READ) || in_hold || in_sum;
      Done         = (state_q == ST_FIN);
`ifdef REGFILE_DUMP_CHECKSUM_EN
      DumpData     = in_hold ? data_q : (in_sum ? sum : '0);
      DumpLast     = in_sum;
      DumpSum      = in_sum;
`else
      DumpData     = in_hold ? data_q : '0;
      DumpLast     = in_hold && (cur_q == last_q);
      DumpSum      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register-file array model, beat queue built
// from the range rules, per-cycle comparison plus literal beat expectations.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
      logic        sum;
      int          cyc;
   } beat_t;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        Start = 1'b0;
   logic [4:0]  FirstReg = '0;
   logic [4:0]  LastReg = '0;
   logic [4:0]  ReadRegister;
   logic [31:0] ReadData;
   logic        DumpValid;
   logic        DumpReady = 1'b1;
   logic [4:0]  DumpIndex;
   logic [31:0] DumpData;
   logic        DumpLast;
   logic        DumpSum;
   logic        Busy;
   logic        Done;

   logic [31:0] regs [32];
   assign ReadData = regs[ReadRegister];

   regfile_dump_reader #(.NUM_REGS(32)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .FirstReg     (FirstReg),
      .LastReg      (LastReg),
      .ReadRegister (ReadRegister),
      .ReadData     (ReadData),
      .DumpValid    (DumpValid),
      .DumpReady    (DumpReady),
      .DumpIndex    (DumpIndex),
      .DumpData     (DumpData),
      .DumpLast     (DumpLast),
      .DumpSum      (DumpSum),
      .Busy         (Busy),
      .Done         (Done)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int    total = 0;
   int    bad = 0;
   beat_t exp_q[$];
   beat_t log_q[$];
   int    done_cnt = 0;
   int    done_cyc = 0;
   int    start_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // Expected beats from the range rule: ((last-first) mod 32)+1 wrapping beats.
   task automatic model_start(input logic [4:0] first, input logic [4:0] last);
      int          n;
      logic [31:0] s;
      logic [4:0]  idx;
      beat_t       b;
      n = ((int'(last) - int'(first)) & 31) + 1;
      s = 0;
      for (int i = 0; i < n; i++) begin
         idx    = 5'(int'(first) + i);
         b.idx  = idx;
         b.data = regs[idx];
         b.last = (i == n - 1) && !CS;
         b.sum  = 1'b0;
         b.cyc  = 0;
         exp_q.push_back(b);
         s += regs[idx];
      end
      if (CS) begin
         b.idx  = 5'd0;
         b.data = s;
         b.last = 1'b1;
         b.sum  = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   always @(negedge Clk) begin
      if (Reset_n) begin
         if (DumpValid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               chk("beat_idx",  DumpIndex, exp_q[0].idx);
               chk("beat_data", DumpData,  exp_q[0].data);
               chk("beat_last", DumpLast,  exp_q[0].last);
               chk("beat_sum",  DumpSum,   exp_q[0].sum);
               if (DumpReady) begin
                  beat_t b;
                  b.idx  = DumpIndex;
                  b.data = DumpData;
                  b.last = DumpLast;
                  b.sum  = DumpSum;
                  b.cyc  = cyc;
                  log_q.push_back(b);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (Done) begin
            chk("busy_at_done", Busy, 0);
            chk("done_beats_left", exp_q.size(), 0);
            done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   task automatic do_start(input logic [4:0] first, input logic [4:0] last);
      @(posedge Clk);
      #1;
      FirstReg = first;
      LastReg  = last;
      Start    = 1'b1;
      start_cyc = cyc;
      log_q.delete();
      model_start(first, last);
      @(posedge Clk);
      #1;
      Start = 1'b0;
      chk("rdreg_first", ReadRegister, first);
      chk("busy_after_start", Busy, 1);
      chk("valid_in_read", DumpValid, 0);
   endtask

   task automatic wait_done();
      int k = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && k < 300) begin
         @(posedge Clk);
         k++;
      end
      if (done_cnt == d0) fail_now("done_timeout");
      #1;
      chk("idle_busy", Busy, 0);
      chk("idle_done", Done, 0);
      chk("idle_valid", DumpValid, 0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rdreg", ReadRegister, 0);
      chk("rst_valid", DumpValid, 0);
      chk("rst_index", DumpIndex, 0);
      chk("rst_data",  DumpData, 0);
      chk("rst_last",  DumpLast, 0);
      chk("rst_sum",   DumpSum, 0);
      chk("rst_busy",  Busy, 0);
      chk("rst_done",  Done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
      regs[0]  = 32'h0;
      regs[1]  = 32'h11;
      regs[5]  = 32'h55;
      regs[8]  = 32'd1;
      regs[9]  = 32'd2;
      regs[10] = 32'd3;
      regs[11] = 32'd4;
      regs[30] = 32'hDEADBEEF;
      regs[31] = 32'd7;

      #2 Reset_n = 1'b0;
      #1 check_reset_outputs();
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;

      // Basic 8..11 dump with literal expectations.
      do_start(5'd8, 5'd11);
      wait_done();
      chk("t1_count", log_q.size(), CS ? 5 : 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_idx",  log_q[i].idx,  8 + i);
         chk("t1_data", log_q[i].data, i + 1);
      end
      for (int i = 0; i < 3; i++) chk("t1_spacing", log_q[i+1].cyc - log_q[i].cyc, 2);
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk("t1_last11", log_q[3].last, 0);
      chk("t1_sumdata", log_q[4].data, 10);
      chk("t1_sumflag", log_q[4].sum, 1);
      chk("t1_sumlast", log_q[4].last, 1);
      chk("t1_sumidx", log_q[4].idx, 0);
`else
      chk("t1_last11", log_q[3].last, 1);
`endif
      chk("t1_done_after_last", done_cyc - log_q[log_q.size()-1].cyc, 1);

      // Backpressure on the index-9 beat for 5 cycles.
      do_start(5'd8, 5'd11);
      k = 0;
      while (!(ReadRegister == 5'd9 && !DumpValid) && k < 50) begin
         @(posedge Clk);
         #1;
         k++;
      end
      if (k >= 50) fail_now("t2_reach9_timeout");
      DumpReady = 1'b0;
      repeat (5) begin
         @(posedge Clk);
         #1;
         chk("t2_stall_valid", DumpValid, 1);
         chk("t2_stall_idx", DumpIndex, 9);
         chk("t2_stall_data", DumpData, 2);
      end
      DumpReady = 1'b1;
      wait_done();
      chk("t2_count", log_q.size(), CS ? 5 : 4);
      chk("t2_idx9", log_q[1].idx, 9);
      chk("t2_data9", log_q[1].data, 2);
      chk("t2_idx10", log_q[2].idx, 10);

      // Wrapping range 30..1.
      do_start(5'd30, 5'd1);
      wait_done();
      chk("t3_count", log_q.size(), CS ? 5 : 4);
      chk("t3_idx0", log_q[0].idx, 30);
      chk("t3_idx1", log_q[1].idx, 31);
      chk("t3_idx2", log_q[2].idx, 0);
      chk("t3_idx3", log_q[3].idx, 1);
      chk("t3_dat0", log_q[0].data, 32'hDEADBEEF);
      chk("t3_dat1", log_q[1].data, 7);
      chk("t3_dat2", log_q[2].data, 0);
      chk("t3_dat3", log_q[3].data, 32'h11);

      // Start while busy must be ignored.
      do_start(5'd12, 5'd14);
      @(posedge Clk);
      #1;
      FirstReg = 5'd2;
      LastReg  = 5'd2;
      Start    = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      wait_done();
      chk("t4_count", log_q.size(), CS ? 4 : 3);
      chk("t4_idx0", log_q[0].idx, 12);
      chk("t4_idx2", log_q[2].idx, 14);
      repeat (3) @(posedge Clk);
      #1;
      chk("t4_no_restart", Busy, 0);

      // Reset in the HOLD of the second beat, then a single-register dump.
      do_start(5'd8, 5'd11);
      k = 0;
      while (!(DumpValid && DumpIndex == 5'd9) && k < 50) begin
         @(posedge Clk);
         #1;
         k++;
      end
      if (k >= 50) fail_now("t5_reach9_timeout");
      #2 Reset_n = 1'b0;
      #1 check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      do_start(5'd5, 5'd5);
      wait_done();
      chk("t5_count", log_q.size(), CS ? 2 : 1);
      chk("t5_idx", log_q[0].idx, 5);
      chk("t5_data", log_q[0].data, 32'h55);
      chk("t5_start_to_done", done_cyc - start_cyc, CS ? 4 : 3);
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk("t5_sum", log_q[1].data, 32'h55);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
